// File: rtl/latch_pkg.sv
// Shared constants and helpers for the latch_pipeline elastic buffer.
package latch_pkg;

    localparam int unsigned LATCH_MAX_DEPTH = 64;

    // Width of an occupancy counter able to hold 0..depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return unsigned'($clog2(depth + 1));
    endfunction

endpackage

// File: rtl/latch_stage.sv
// One storage stage of latch_pipeline: data/valid registers plus the stage's ready term.
module latch_stage
    import latch_pkg::*;
#(
    parameter int unsigned  N    = 32,
    parameter logic [N-1:0] Rval = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         en_i,
    input  logic         vld_i,
    input  logic [N-1:0] data_i,
    input  logic         nxt_rdy_i,
    output logic         vld_o,
    output logic [N-1:0] data_o
);

    logic         vld_q, vld_d;
    logic [N-1:0] data_q, data_d;
    logic         rdy;

    assign rdy = ~vld_q | nxt_rdy_i;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (en_i && rdy) begin
            vld_d = vld_i;
            // Bubbles leave data alone so the output keeps its last valid word.
            if (vld_i) begin
                data_d = data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            data_q <= Rval;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/latch_pipeline.sv
// DEPTH-stage elastic valid/ready buffer with global freeze enable and programmable reset value.
// Define LATCH_PIPELINE_COUNT_EN to add the `count` occupancy port.
module latch_pipeline
    import latch_pkg::*;
#(
    parameter int unsigned  N     = 32,
    parameter int unsigned  DEPTH = 2,
    parameter logic [N-1:0] Rval  = {N{1'b0}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N-1:0]              d,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [N-1:0]              o,
    output logic                      out_valid,
    input  logic                      out_ready
`ifdef LATCH_PIPELINE_COUNT_EN
    ,
    output logic [cnt_w(DEPTH)-1:0]   count
`endif
);

    if (DEPTH < 1 || DEPTH > LATCH_MAX_DEPTH) begin : g_bad_depth
        $error("latch_pipeline: DEPTH must be within 1..64");
    end
    if (DEPTH > 8) begin : g_deep
        $warning("latch_pipeline: DEPTH > 8, combinational ready chain is timing-critical");
    end

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] nxt_rdy;
    logic [N-1:0]     data [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic         s_vld;
        logic [N-1:0] s_data;

        if (k == 0) begin : g_head
            assign s_vld  = in_valid;
            assign s_data = d;
        end else begin : g_body
            assign s_vld  = vld[k-1];
            assign s_data = data[k-1];
        end

        // Unrolled ready chain: downstream can take a word unless every later stage is
        // occupied and the consumer stalls. Written from vld directly to keep it loop-free.
        if (k == DEPTH - 1) begin : g_tail
            assign nxt_rdy[k] = out_ready;
        end else begin : g_link
            assign nxt_rdy[k] = out_ready | ~(&vld[DEPTH-1:k+1]);
        end

        latch_stage #(
            .N    (N),
            .Rval (Rval)
        ) u_stage (
            .clk_i     (clk),
            .rst_i     (rst),
            .en_i      (en),
            .vld_i     (s_vld),
            .data_i    (s_data),
            .nxt_rdy_i (nxt_rdy[k]),
            .vld_o     (vld[k]),
            .data_o    (data[k])
        );
    end

    assign in_ready  = en & (~vld[0] | nxt_rdy[0]);
    assign out_valid = en & vld[DEPTH-1];
    assign o         = data[DEPTH-1];

`ifdef LATCH_PIPELINE_COUNT_EN
    localparam int unsigned CntW = cnt_w(DEPTH);

    logic            in_xfer, out_xfer;
    logic [CntW-1:0] count_q, count_d;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        if (in_xfer && !out_xfer) begin
            count_d = count_q + CntW'(1);
        end else if (out_xfer && !in_xfer) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifndef SYNTHESIS
    count_matches_vld : assert property (@(posedge clk) disable iff (rst)
        count_q == CntW'($countones(vld)));
`endif
`endif

endmodule

// File: tb/tb_latch_pipeline.sv
// Directed bench for latch_pipeline (N=8, DEPTH=3, Rval=8'hA5); count checked with LATCH_PIPELINE_COUNT_EN.
module tb_latch_pipeline;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] d;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] o;
    logic       out_valid;
    logic       out_ready;
`ifdef LATCH_PIPELINE_COUNT_EN
    logic [1:0] count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    latch_pipeline #(
        .N     (8),
        .DEPTH (3),
        .Rval  (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .d         (d),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .o         (o),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef LATCH_PIPELINE_COUNT_EN
        ,
        .count     (count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, check outputs before the edge, then advance one clock.
    task automatic vec(input string tag, input logic e, input logic r, input logic iv,
                       input logic [7:0] din, input logic ordy, input logic xir,
                       input logic xov, input logic [7:0] xo, input logic [1:0] xcnt);
        en        = e;
        rst       = r;
        in_valid  = iv;
        d         = din;
        out_ready = ordy;
        #1;
        check_eq({tag, ".in_ready"}, 32'(in_ready), 32'(xir));
        check_eq({tag, ".out_valid"}, 32'(out_valid), 32'(xov));
        check_eq({tag, ".o"}, 32'(o), 32'(xo));
`ifdef LATCH_PIPELINE_COUNT_EN
        check_eq({tag, ".count"}, 32'(count), 32'(xcnt));
`else
        if (xcnt > 2'd3) $display("unreachable");
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        en = 1'b1; rst = 1'b1; in_valid = 1'b0; d = 8'h00; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;

        // Reset state, still in reset
        vec("reset", 1, 1, 0, 8'h00, 0, 1, 0, 8'hA5, 2'd0);

        // Streaming 8'h01..8'h10, first valid three cycles after first offer
        for (int c = 0; c < 20; c++) begin
            logic       iv;
            logic       xov;
            logic [7:0] xo;
            int         acc;
            int         outs;
            iv   = (c < 16);
            xov  = (c >= 3 && c < 19);
            xo   = (c < 3) ? 8'hA5 : ((c < 19) ? 8'(c - 2) : 8'h10);
            acc  = (c < 16) ? c : 16;
            outs = (c < 4) ? 0 : (((c < 19) ? c : 19) - 3);
            vec($sformatf("stream%0d", c), 1, 0, iv, iv ? 8'(c + 1) : 8'h00, 1,
                1, xov, xo, 2'(acc - outs));
        end

        // Back-pressure: 4 offered, 3 accepted, then drain in order
        vec("bp0", 1, 0, 1, 8'h21, 0, 1, 0, 8'h10, 2'd0);
        vec("bp1", 1, 0, 1, 8'h22, 0, 1, 0, 8'h10, 2'd1);
        vec("bp2", 1, 0, 1, 8'h23, 0, 1, 0, 8'h10, 2'd2);
        vec("bp3", 1, 0, 1, 8'h24, 0, 0, 1, 8'h21, 2'd3);
        vec("dr0", 1, 0, 0, 8'h00, 1, 1, 1, 8'h21, 2'd3);
        vec("dr1", 1, 0, 0, 8'h00, 1, 1, 1, 8'h22, 2'd2);
        vec("dr2", 1, 0, 0, 8'h00, 1, 1, 1, 8'h23, 2'd1);
        vec("dr3", 1, 0, 0, 8'h00, 1, 1, 0, 8'h23, 2'd0);

        // Freeze mid-stream for 5 cycles, then resume without loss or duplication
        vec("fz_a", 1, 0, 1, 8'h31, 1, 1, 0, 8'h23, 2'd0);
        vec("fz_b", 1, 0, 1, 8'h32, 1, 1, 0, 8'h23, 2'd1);
        for (int i = 0; i < 5; i++) begin
            vec($sformatf("frozen%0d", i), 0, 0, 1, 8'h33, 1, 0, 0, 8'h23, 2'd2);
        end
        vec("rs0", 1, 0, 1, 8'h33, 1, 1, 0, 8'h23, 2'd2);
        vec("rs1", 1, 0, 1, 8'h34, 1, 1, 1, 8'h31, 2'd3);
        vec("rs2", 1, 0, 0, 8'h00, 1, 1, 1, 8'h32, 2'd3);
        vec("rs3", 1, 0, 0, 8'h00, 1, 1, 1, 8'h33, 2'd2);
        vec("rs4", 1, 0, 0, 8'h00, 1, 1, 1, 8'h34, 2'd1);
        vec("rs5", 1, 0, 0, 8'h00, 1, 1, 0, 8'h34, 2'd0);

        // Fill, then full with out_ready=1: one in, one out per cycle
        vec("fill0", 1, 0, 1, 8'h41, 0, 1, 0, 8'h34, 2'd0);
        vec("fill1", 1, 0, 1, 8'h42, 0, 1, 0, 8'h34, 2'd1);
        vec("fill2", 1, 0, 1, 8'h43, 0, 1, 0, 8'h34, 2'd2);
        vec("thru0", 1, 0, 1, 8'h44, 1, 1, 1, 8'h41, 2'd3);
        vec("thru1", 1, 0, 1, 8'h45, 1, 1, 1, 8'h42, 2'd3);
        vec("thru2", 1, 0, 1, 8'h46, 1, 1, 1, 8'h43, 2'd3);

        // Drain one to leave two in flight, then reset coincident with transfers
        vec("pre_rst", 1, 0, 0, 8'h00, 1, 1, 1, 8'h44, 2'd3);
        vec("rst_mid", 1, 1, 1, 8'h47, 1, 1, 1, 8'h45, 2'd2);
        vec("post_rst0", 1, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 2'd0);
        vec("post_rst1", 1, 0, 0, 8'h00, 1, 1, 0, 8'hA5, 2'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/latch_pipeline.md
# latch_pipeline

Synchronous, parametrised successor to the single-stage level-sensitive latch primitive. It chains `DEPTH` storage stages, each `N` bits wide, into an elastic valid/ready pipeline. This gives the clocked half of the design a multi-stage hold/forward buffer with a programmable reset value and a global freeze enable. It sits between producer and consumer blocks that need buffering and back-pressure, replacing hand-chained latch instances.

## Interface
Parameters:
- `N`, 32: data width per stage.
- `DEPTH`, 2: number of stages; legal range 1..64.
- `Rval`, `{N{1'b0}}`: reset value loaded into every stage's data register.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `en`, in, 1: global enable; low freezes the whole pipeline.
- `d`, in, N: input data.
- `in_valid`, in, 1: producer offers `d`.
- `in_ready`, out, 1: pipeline accepts `d` this cycle.
- `o`, out, N: data of the last stage.
- `out_valid`, out, 1: `o` holds a valid word.
- `out_ready`, in, 1: consumer takes `o` this cycle.
- `count`, out, `$clog2(DEPTH+1)`: present only with `LATCH_PIPELINE_COUNT_EN`; number of occupied stages.

## Operation
- Each stage k (0 = input side, DEPTH-1 = output side) holds `data[k]` (N bits) and `vld[k]` (1 bit).
- Stage ready, computed combinationally from the output side back:
  - `rdy[DEPTH-1] = ~vld[DEPTH-1] | out_ready`
  - `rdy[k] = ~vld[k] | rdy[k+1]`
- Outputs:
  - `in_ready = en & rdy[0]`
  - `out_valid = en & vld[DEPTH-1]`
  - `o = data[DEPTH-1]`, always driven even when not valid.
- Transfers:
  - Input transfer: `in_valid & in_ready`.
  - Output transfer: `out_valid & out_ready`.
- Per-cycle update when `en`=1 and `rst`=0:
  - Stage 0 loads `d` when `rdy[0]`, and its `vld` becomes `in_valid`.
  - Stage k>0 loads `data[k-1]` when `rdy[k]`, and its `vld` becomes `vld[k-1]`.
  - A stage whose `rdy` is low holds both data and `vld`.
  - Data registers load only when the incoming `vld` is 1. Bubbles never overwrite data, so `o` keeps its last valid word.
- `en`=0: no register changes; `in_ready` and `out_valid` are forced low, so no transfer occurs on either side.
- `rst`=1: all `vld` cleared, all `data` set to `Rval`, `count` set to 0. Reset takes priority over `en` and over any transfer in the same cycle, and discards in-flight words when asserted mid-operation.
- Reset values of outputs: `in_ready = en`, `out_valid = 0`, `o = Rval`, `count = 0`.

## Timing
- Latency: a word accepted at edge t appears with `out_valid`=1 after edge t+DEPTH-1 when the pipeline is empty. With DEPTH=1 it is visible the cycle after acceptance.
- Throughput: 1 word/cycle sustained while `out_ready`=1 and `en`=1.
- Full condition: all `vld`=1 and `out_ready`=0, which gives `in_ready`=0.
- Full and `out_ready`=1: input and output transfers occur in the same cycle and occupancy is unchanged.
- The ready chain is combinational across all stages. `DEPTH` above 8 is a timing risk and must be flagged in synthesis reports.
- No combinational path from `d` to `o`; combinational paths run from `out_ready` and `en` to `in_ready`, and from `en` to `out_valid`.

## Configuration
- `LATCH_PIPELINE_COUNT_EN` defined:
  - Adds the `count` port and an up/down counter.
  - Counter: +1 on an input transfer only, −1 on an output transfer only, unchanged when both or neither occur.
  - Saturation is impossible by construction, and the counter always equals popcount(`vld`).
- Undefined: no `count` port and no counter logic; all other behaviour identical.

## Structure
- Shared package `latch_pkg`:
  - `LATCH_MAX_DEPTH = 64` constant.
  - `cnt_w(depth)` function returning `$clog2(depth+1)`.
- One sub-module, `latch_stage`: holds one stage's data/vld registers and its ready term. Instantiated `DEPTH` times in a generate loop.
- Parameter legality is checked in elaboration (DEPTH 1..64).

## Test plan
- Reset: N=8, Rval=8'hA5, DEPTH=3; `rst` high 2 cycles → `o`=8'hA5, `out_valid`=0, `count`=0, `in_ready`=1.
- Streaming: DEPTH=3, `out_ready`=1, inject 8'h01..8'h10 back-to-back → outputs in order, first valid 3 cycles after first accept, no gaps.
- Back-pressure: `out_ready`=0, inject 4 words into DEPTH=3 → 3 accepted, `in_ready`=0, `count`=3; release → words drain in order with `count` 3→0.
- Freeze: mid-stream, drive `en`=0 for 5 cycles → `in_ready`=0, `out_valid`=0, state and `o` unchanged; resume with no loss or duplication.
- Simultaneous full and drain: full pipeline, `out_ready`=1 and `in_valid`=1 → one word in and one out per cycle, `count` stays 3.
- Reset mid-operation: 2 words in flight, assert `rst` in the same cycle as a transfer → all `vld`=0, `o`=Rval, no output transfer.
